// File: rtl/mem_loader_if.sv
// Bus between the word producer / max-finder datapath and mem_loader.
// Groups the load handshake, the load status and the synchronous read port.
// The optional running-sum output exists only when MEM_LOADER_SUM_EN is defined.
interface mem_loader_if #(
    parameter int DW = 4,
    parameter int AW = 4
);
    logic          start;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic [AW-1:0] wr_addr;
    logic          busy;
    logic          loaded;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
`ifdef MEM_LOADER_SUM_EN
    logic [DW+AW-1:0] sum;

    modport master (
        output start, in_valid, in_data, rd_addr,
        input  in_ready, wr_addr, busy, loaded, rd_data, sum
    );

    modport slave (
        input  start, in_valid, in_data, rd_addr,
        output in_ready, wr_addr, busy, loaded, rd_data, sum
    );
`else
    modport master (
        output start, in_valid, in_data, rd_addr,
        input  in_ready, wr_addr, busy, loaded, rd_data
    );

    modport slave (
        input  start, in_valid, in_data, rd_addr,
        output in_ready, wr_addr, busy, loaded, rd_data
    );
`endif
endinterface

// File: rtl/mem_loader.sv
// mem_loader: write side of the max-finder data memory.
// A load pass writes a valid/ready word stream to addresses 0..MAXADDR, then
// parks in DONE until the next start. A registered read port (latency 1,
// read-before-write on address collision) serves the max-finder MAR/MDR.
// Optional feature macro: MEM_LOADER_SUM_EN adds a running sum of the words
// accepted in the current pass.
module mem_loader #(
    parameter int            DW      = 4,
    parameter int            AW      = 4,
    parameter logic [AW-1:0] MAXADDR = {AW{1'b1}}
) (
    input  logic         clk,
    input  logic         reset,
    mem_loader_if.slave  bus
);
    localparam int DEPTH = 2 ** AW;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [DW-1:0] rd_data_q, rd_data_d;
    logic          wr_en_s;
    logic          mem_we_s;
    logic          enter_load_s;
    logic [DW-1:0] mem_q [DEPTH];

    // Next-state logic: pass sequencing, write address advance and write enable.
    always_comb begin
        state_d      = state_q;
        wr_addr_d    = wr_addr_q;
        wr_en_s      = 1'b0;
        enter_load_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d      = ST_LOAD;
                    wr_addr_d    = {AW{1'b0}};
                    enter_load_s = 1'b1;
                end else begin
                    state_d      = ST_IDLE;
                end
            end
            ST_LOAD: begin
                // start is deliberately ignored here: a pass never restarts itself.
                if (bus.in_valid) begin
                    wr_en_s = 1'b1;
                    if (wr_addr_q == MAXADDR) begin
                        // Last word: hold the address, no wrap within a pass.
                        state_d   = ST_DONE;
                        wr_addr_d = MAXADDR;
                    end else begin
                        wr_addr_d = wr_addr_q + AW'(1'b1);
                    end
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_DONE: begin
                if (bus.start) begin
                    state_d      = ST_LOAD;
                    wr_addr_d    = {AW{1'b0}};
                    enter_load_s = 1'b1;
                end else begin
                    state_d      = ST_DONE;
                end
            end
            default: begin
                // Unreachable encoding: recover to a clean idle state.
                state_d   = ST_IDLE;
                wr_addr_d = {AW{1'b0}};
            end
        endcase
    end

    // Read mux feeding the registered read data.
    always_comb begin
        rd_data_d = mem_q[bus.rd_addr];
    end

    // A word arriving in the same cycle as reset is not written.
    assign mem_we_s = wr_en_s & ~reset;

    // Control and read-data registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            wr_addr_q <= {AW{1'b0}};
            rd_data_q <= {DW{1'b0}};
        end else begin
            state_q   <= state_d;
            wr_addr_q <= wr_addr_d;
            rd_data_q <= rd_data_d;
        end
    end

    // Memory array write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_q[wr_addr_q] <= bus.in_data;
        end
    end

    assign bus.in_ready = (state_q == ST_LOAD);
    assign bus.busy     = (state_q == ST_LOAD);
    assign bus.loaded   = (state_q == ST_DONE);
    assign bus.wr_addr  = wr_addr_q;
    assign bus.rd_data  = rd_data_q;

`ifdef MEM_LOADER_SUM_EN
    logic [DW+AW-1:0] sum_q, sum_d;

    // Running sum: cleared when a pass begins, accumulated with each write.
    always_comb begin
        sum_d = sum_q;
        if (enter_load_s) begin
            sum_d = {(DW+AW){1'b0}};
        end else if (wr_en_s) begin
            sum_d = sum_q + {{AW{1'b0}}, bus.in_data};
        end else begin
            sum_d = sum_q;
        end
    end

    // Running-sum register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            sum_q <= {(DW+AW){1'b0}};
        end else begin
            sum_q <= sum_d;
        end
    end

    assign bus.sum = sum_q;
`endif
endmodule

// File: tb/tb_mem_loader.sv
// Testbench for mem_loader: two instances (MAXADDR=15 and MAXADDR=0) share one
// stimulus stream; a pass-level reference model pushes expected outputs into
// per-instance queues and a monitor pops and compares them each cycle.
module tb_mem_loader;
    localparam int DW = 4;
    localparam int AW = 4;

    logic       clk = 1'b0;
    logic       reset_s = 1'b1;
    logic       start_s = 1'b0;
    logic       in_valid_s = 1'b0;
    logic [3:0] in_data_s = 4'h0;
    logic [3:0] rd_addr_s = 4'h0;

    always #5 clk = ~clk;

    mem_loader_if #(.DW(DW), .AW(AW)) bus0 ();
    mem_loader_if #(.DW(DW), .AW(AW)) bus1 ();

    assign bus0.start    = start_s;
    assign bus0.in_valid = in_valid_s;
    assign bus0.in_data  = in_data_s;
    assign bus0.rd_addr  = rd_addr_s;
    assign bus1.start    = start_s;
    assign bus1.in_valid = in_valid_s;
    assign bus1.in_data  = in_data_s;
    assign bus1.rd_addr  = rd_addr_s;

    mem_loader #(.DW(DW), .AW(AW), .MAXADDR(4'hF)) dut0 (.clk(clk), .reset(reset_s), .bus(bus0));
    mem_loader #(.DW(DW), .AW(AW), .MAXADDR(4'h0)) dut1 (.clk(clk), .reset(reset_s), .bus(bus1));

    typedef struct {
        bit         rd_chk;
        logic [3:0] rd;
        logic       rdy;
        logic [3:0] wa;
        logic       busy;
        logic       loaded;
        logic [7:0] sum;
    } exp_t;

    exp_t sb0[$];
    exp_t sb1[$];

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: one pass descriptor per instance plus a shadow memory.
    int         m_last[2];
    bit         m_loading[2];
    bit         m_done[2];
    int         m_addr[2];
    int         m_sum[2];
    logic [3:0] m_mem[2][16];
    bit         m_known[2][16];

    task automatic chk(input string nm, input int k, input logic [7:0] act, input logic [7:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s inst%0d got=%0h exp=%0h t=%0t", nm, k, act, expv, $time);
        end
    endtask

    function automatic exp_t model_step(input int k, input bit rst, input bit st, input bit v,
                                        input logic [3:0] d, input logic [3:0] ra);
        exp_t e;
        e.rd_chk = rst || m_known[k][ra];
        e.rd     = rst ? 4'h0 : m_mem[k][ra];
        if (rst) begin
            m_loading[k] = 1'b0;
            m_done[k]    = 1'b0;
            m_addr[k]    = 0;
            m_sum[k]     = 0;
        end else if (m_loading[k]) begin
            if (v) begin
                m_mem[k][m_addr[k]]   = d;
                m_known[k][m_addr[k]] = 1'b1;
                m_sum[k] += int'(d);
                if (m_addr[k] == m_last[k]) begin
                    m_loading[k] = 1'b0;
                    m_done[k]    = 1'b1;
                end else begin
                    m_addr[k]++;
                end
            end
        end else if (st) begin
            m_loading[k] = 1'b1;
            m_done[k]    = 1'b0;
            m_addr[k]    = 0;
            m_sum[k]     = 0;
        end
        e.rdy    = m_loading[k];
        e.busy   = m_loading[k];
        e.loaded = m_done[k];
        e.wa     = 4'(m_addr[k]);
        e.sum    = 8'(m_sum[k]);
        return e;
    endfunction

    // One stimulus cycle: drive on the falling edge, record expectations.
    task automatic cyc(input bit rst, input bit st, input bit v, input logic [3:0] d, input logic [3:0] ra);
        @(negedge clk);
        reset_s    = rst;
        start_s    = st;
        in_valid_s = v;
        in_data_s  = d;
        rd_addr_s  = ra;
        sb0.push_back(model_step(0, rst, st, v, d, ra));
        sb1.push_back(model_step(1, rst, st, v, d, ra));
    endtask

    task automatic compare(input int k, input exp_t e, input logic rdy, input logic [3:0] wa,
                           input logic busy, input logic loaded, input logic [3:0] rd,
                           input logic [7:0] sm);
        chk("in_ready", k, {7'd0, rdy}, {7'd0, e.rdy});
        chk("wr_addr", k, {4'd0, wa}, {4'd0, e.wa});
        chk("busy", k, {7'd0, busy}, {7'd0, e.busy});
        chk("loaded", k, {7'd0, loaded}, {7'd0, e.loaded});
        if (e.rd_chk) begin
            chk("rd_data", k, {4'd0, rd}, {4'd0, e.rd});
        end
`ifdef MEM_LOADER_SUM_EN
        chk("sum", k, sm, e.sum);
`else
        if (sm !== 8'h00) begin
            chk("sum_tie", k, sm, 8'h00);
        end
`endif
    endtask

    // Monitor: after each rising edge, compare DUT outputs with queued expectations.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb0.size() > 0) begin
                e = sb0.pop_front();
`ifdef MEM_LOADER_SUM_EN
                compare(0, e, bus0.in_ready, bus0.wr_addr, bus0.busy, bus0.loaded, bus0.rd_data, bus0.sum);
`else
                compare(0, e, bus0.in_ready, bus0.wr_addr, bus0.busy, bus0.loaded, bus0.rd_data, 8'h00);
`endif
            end
            if (sb1.size() > 0) begin
                e = sb1.pop_front();
`ifdef MEM_LOADER_SUM_EN
                compare(1, e, bus1.in_ready, bus1.wr_addr, bus1.busy, bus1.loaded, bus1.rd_data, bus1.sum);
`else
                compare(1, e, bus1.in_ready, bus1.wr_addr, bus1.busy, bus1.loaded, bus1.rd_data, 8'h00);
`endif
            end
        end
    end

    // Stimulus: directed scenarios followed by a randomized phase.
    initial begin
        m_last[0] = 15;
        m_last[1] = 0;
        for (int k = 0; k < 2; k++) begin
            m_loading[k] = 1'b0;
            m_done[k]    = 1'b0;
            m_addr[k]    = 0;
            m_sum[k]     = 0;
            for (int a = 0; a < 16; a++) begin
                m_mem[k][a]   = 4'h0;
                m_known[k][a] = 1'b0;
            end
        end

        cyc(1'b1, 1'b0, 1'b0, 4'h0, 4'h0);
        cyc(1'b1, 1'b0, 1'b0, 4'h0, 4'h0);
        cyc(1'b0, 1'b0, 1'b0, 4'h0, 4'h0);

        // Full pass 0..15 with in_valid held, then read back.
        cyc(1'b0, 1'b1, 1'b0, 4'h0, 4'h0);
        for (int i = 0; i < 16; i++) cyc(1'b0, 1'b0, 1'b1, 4'(i), 4'(i));
        for (int i = 0; i < 17; i++) cyc(1'b0, 1'b0, 1'b0, 4'h0, 4'(i));

        // Toggling valid with start pulsed mid-pass; data puts 4'h2 at address 3.
        cyc(1'b0, 1'b1, 1'b0, 4'h0, 4'h0);
        for (int i = 0; i < 32; i++)
            cyc(1'b0, (i == 9), (i % 2 == 0), 4'(i / 2) ^ 4'h1, 4'($urandom_range(15)));

        // In DONE: valid data must be dropped, memory unchanged.
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b1, 4'hA, 4'(i));
        for (int i = 0; i < 17; i++) cyc(1'b0, 1'b0, 1'b0, 4'h0, 4'(i));

        // Restart, then read/write collision at address 3, then reset after 5 accepts.
        cyc(1'b0, 1'b1, 1'b0, 4'h0, 4'h3);
        for (int j = 0; j < 5; j++) cyc(1'b0, 1'b0, 1'b1, (j == 3) ? 4'h7 : 4'(j), 4'h3);
        cyc(1'b1, 1'b0, 1'b0, 4'h0, 4'h3);
        for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, 1'b0, 4'h0, 4'(i));

        // Maximum-sum pass of 4'hF words, then a restart clears the sum.
        cyc(1'b0, 1'b1, 1'b0, 4'h0, 4'h0);
        for (int i = 0; i < 16; i++) cyc(1'b0, 1'b0, 1'b1, 4'hF, 4'(i));
        cyc(1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
        cyc(1'b0, 1'b1, 1'b0, 4'h0, 4'h0);
        cyc(1'b0, 1'b0, 1'b0, 4'h0, 4'h0);

        // Randomized phase.
        for (int i = 0; i < 3000; i++)
            cyc(($urandom_range(63) == 0), ($urandom_range(7) == 0), 1'($urandom_range(1)),
                4'($urandom_range(15)), 4'($urandom_range(15)));
        cyc(1'b0, 1'b0, 1'b0, 4'h0, 4'h0);

        // Let the monitor drain, bounded.
        for (int w = 0; w < 10 && (sb0.size() > 0 || sb1.size() > 0); w++) @(posedge clk);
        @(negedge clk);
        chk("sb0_drained", 0, 8'(sb0.size()), 8'h00);
        chk("sb1_drained", 1, 8'(sb1.size()), 8'h00);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
